// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage 16-bit pipeline: controller state
// encoding, HLT opcode and the hard-wired zero register.
package cpu_pkg;

    localparam logic [2:0] S_RUN    = 3'd0;
    localparam logic [2:0] S_ISTALL = 3'd1;
    localparam logic [2:0] S_DSTALL = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_HALTED = 3'd4;

    typedef enum logic [2:0] {
        RUN    = S_RUN,
        ISTALL = S_ISTALL,
        DSTALL = S_DSTALL,
        DRAIN  = S_DRAIN,
        HALTED = S_HALTED
    } hz_state_t;

    localparam logic [3:0] OPC_HLT  = 4'hF;
    localparam logic [3:0] REG_ZERO = 4'h0;

    // Drain counter width; covers DRAIN_CYCLES up to 7.
    localparam int DRAIN_W = 3;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use hazard compare between the load in EX and the instruction in ID.
// Purely combinational so the forwarding checker can reuse it unchanged.
module hazard_detect
    import cpu_pkg::*;
(
    input  logic       idex_memread_i,
    input  logic [3:0] idex_rd_i,
    input  logic [3:0] ifid_rs_i,
    input  logic [3:0] ifid_rt_i,
    input  logic       ifid_uses_rt_i,
    output logic       luh_o
);

    // R0 is never a real dependency, so a load targeting it never stalls.
    assign luh_o = idex_memread_i
                 & (idex_rd_i != REG_ZERO)
                 & ((idex_rd_i == ifid_rs_i)
                    | (ifid_uses_rt_i & (idex_rd_i == ifid_rt_i)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer: drives pipeline register enables/clears for
// load-use, taken-branch, cache-miss and HLT-drain events, and counts cycles
// in which the PC is held.
module pipe_hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       ifid_rs,
    input  logic [3:0]       ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic             idex_memread,
    input  logic [3:0]       idex_rd,
    input  logic             branch_taken,
    input  logic             halt_id,
    input  logic             icache_miss,
    input  logic             dcache_miss,
    input  logic             mem_ready,
    output logic             pc_wen,
    output logic             ifid_wen,
    output logic             ifid_flush,
    output logic             idex_wen,
    output logic             idex_flush,
    output logic             exmem_wen,
    output logic             memwb_wen,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(DRAIN_CYCLES);

    hz_state_t           state_q, state_d;
    logic [DRAIN_W-1:0]  drain_q, drain_d;
    logic                frz_q, frz_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic                luh;
    logic                freeze;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    hazard_detect u_hazard_detect (
        .idex_memread_i (idex_memread),
        .idex_rd_i      (idex_rd),
        .ifid_rs_i      (ifid_rs),
        .ifid_rt_i      (ifid_rt),
        .ifid_uses_rt_i (ifid_uses_rt),
        .luh_o          (luh)
    );

    // State, drain counter, drain-freeze flag and stall counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            drain_q     <= '0;
            frz_q       <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            frz_q       <= frz_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Next-state and Mealy enable/flush decode; freeze zeroes every enable.
    always_comb begin
        state_d    = state_q;
        drain_d    = drain_q;
        frz_d      = frz_q;
        freeze     = 1'b0;
        pc_wen     = 1'b1;
        ifid_wen   = 1'b1;
        ifid_flush = 1'b0;
        idex_wen   = 1'b1;
        idex_flush = 1'b0;
        exmem_wen  = 1'b1;
        memwb_wen  = 1'b1;
        halted     = 1'b0;
        unique case (state_q)
            RUN: begin
                if (dcache_miss) begin
                    freeze  = 1'b1;
                    state_d = DSTALL;
                end else if (icache_miss) begin
                    pc_wen     = 1'b0;
                    ifid_flush = 1'b1;
                    state_d    = ISTALL;
                end else if (luh) begin
                    // Outranks branch_taken: the branch re-resolves next
                    // cycle once the loaded value can be forwarded.
                    pc_wen     = 1'b0;
                    ifid_wen   = 1'b0;
                    idex_flush = 1'b1;
                end else if (branch_taken) begin
                    ifid_flush = 1'b1;
                end else if (halt_id) begin
                    pc_wen     = 1'b0;
                    ifid_wen   = 1'b0;
                    idex_flush = 1'b1;
                    drain_d    = DRAIN_INIT;
                    frz_d      = 1'b0;
                    state_d    = DRAIN;
                end
            end
            DSTALL: begin
                if (mem_ready) begin
                    state_d = RUN;
                end else begin
                    freeze = 1'b1;
                end
            end
            ISTALL: begin
                if (dcache_miss) begin
                    // Fetch re-requests its line after the data fill.
                    freeze  = 1'b1;
                    state_d = DSTALL;
                end else if (mem_ready) begin
                    state_d = RUN;
                end else begin
                    pc_wen     = 1'b0;
                    ifid_flush = 1'b1;
                end
            end
            DRAIN: begin
                if ((frz_q && !mem_ready) || (!frz_q && dcache_miss)) begin
                    freeze = 1'b1;
                    frz_d  = 1'b1;
                end else begin
                    frz_d      = 1'b0;
                    pc_wen     = 1'b0;
                    ifid_wen   = 1'b0;
                    idex_flush = 1'b1;
                    drain_d    = drain_q - 1'b1;
                    if (drain_q <= DRAIN_W'(1)) begin
                        drain_d = '0;
                        state_d = HALTED;
                    end
                end
            end
            HALTED: begin
                freeze = 1'b1;
                halted = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
        if (freeze) begin
            pc_wen     = 1'b0;
            ifid_wen   = 1'b0;
            ifid_flush = 1'b0;
            idex_wen   = 1'b0;
            idex_flush = 1'b0;
            exmem_wen  = 1'b0;
            memwb_wen  = 1'b0;
        end
        // Outputs take their reset values immediately while rst is high;
        // ID/EX is cleared so the pipe restarts on a bubble.
        if (rst) begin
            pc_wen     = 1'b1;
            ifid_wen   = 1'b1;
            ifid_flush = 1'b0;
            idex_wen   = 1'b1;
            idex_flush = 1'b1;
            exmem_wen  = 1'b1;
            memwb_wen  = 1'b1;
            halted     = 1'b0;
        end
    end

    // Count held-PC cycles outside HALTED, saturating at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_wen && (state_q != HALTED)) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule
